// File: rtl/c34_stress_sched.sv
//==============================================================================
// Module      : c34_stress_sched
// Description : Stress/measure scheduler for two c17-style core slices. It
//               alternates a static stress vector with LFSR patterns and counts
//               mismatching response bits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module c34_stress_sched #(
    parameter int unsigned STRESS_CYC = 16,
    parameter int unsigned MEAS_CYC   = 8,
    parameter logic [9:0]  LFSR_SEED  = 10'h2A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  stress_vec,
    input  logic [7:0]  n_rounds,
    output logic [9:0]  dut_in,
    input  logic [3:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] fail_cnt,
    output logic [7:0]  round_cnt
);

    localparam logic [1:0]  c_st_idle     = 2'd0;
    localparam logic [1:0]  c_st_stress   = 2'd1;
    localparam logic [1:0]  c_st_meas     = 2'd2;
    localparam logic [9:0]  c_seed        = (LFSR_SEED == 10'h000) ? 10'h001 : LFSR_SEED;
    localparam logic [15:0] c_stress_last = 16'(STRESS_CYC - 1);
    localparam logic [15:0] c_meas_last   = 16'(MEAS_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [9:0]  r_dut_in;
    logic [9:0]  r_stress_vec;
    logic [7:0]  r_n_rounds;
    logic [9:0]  r_lfsr;
    logic [15:0] r_phase_cnt;
    logic [15:0] r_fail_cnt;
    logic [7:0]  r_round_cnt;
    logic        r_done;

    logic        w_accept;
    logic        w_zero_run;
    logic        w_abort_run;
    logic        w_run_end;
    logic        w_stress_last;
    logic        w_meas_last;
    logic [7:0]  w_round_inc;
    logic [9:0]  w_lfsr_nxt;
    logic [3:0]  w_golden;
    logic [3:0]  w_mis;
    logic [2:0]  w_nbits;
    logic [16:0] w_fail_sum;
    logic [15:0] w_fail_sat;

    // Golden response for each 5-bit slice: bits {N7,N6,N3,N2,N1}
    for (genvar s = 0; s < 2; s++) begin : g_slice
        logic w_n1, w_n2, w_n3, w_n6, w_n7, w_n11;
        assign {w_n7, w_n6, w_n3, w_n2, w_n1} = r_dut_in[5*s +: 5];
        assign w_n11             = ~(w_n3 & w_n6);
        assign w_golden[2*s]     = (w_n1 & w_n3) | (w_n2 & w_n11);
        assign w_golden[2*s + 1] = w_n11 & (w_n2 | w_n7);
    end

    assign w_mis      = dut_out ^ w_golden;
    assign w_nbits    = {2'b00, w_mis[0]} + {2'b00, w_mis[1]} + {2'b00, w_mis[2]} + {2'b00, w_mis[3]};
    assign w_fail_sum = {1'b0, r_fail_cnt} + {14'd0, w_nbits};
    assign w_fail_sat = w_fail_sum[16] ? 16'hFFFF : w_fail_sum[15:0];

    // x^10 + x^7 + 1: taps on bits 9 and 6, shifting towards the MSB
    assign w_lfsr_nxt    = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    assign w_stress_last = (r_phase_cnt == c_stress_last);
    assign w_meas_last   = (r_phase_cnt == c_meas_last);
    assign w_round_inc   = r_round_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_zero_run  = 1'b0;
        w_abort_run = 1'b0;
        w_run_end   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start && !abort) begin
                    if (n_rounds != 8'd0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = c_st_stress;
                    end else begin
                        w_zero_run = 1'b1;
                    end
                end
            end
            c_st_stress: begin
                if (abort) begin
                    w_abort_run = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (w_stress_last) begin
                    w_state_nxt = c_st_meas;
                end
            end
            c_st_meas: begin
                if (abort) begin
                    w_abort_run = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (w_meas_last) begin
                    if (w_round_inc == r_n_rounds) begin
                        w_run_end   = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_stress;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Datapath: dut_in tracks r_lfsr for the whole MEAS phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dut_in     <= 10'h000;
            r_stress_vec <= 10'h000;
            r_n_rounds   <= 8'd0;
            r_lfsr       <= c_seed;
            r_phase_cnt  <= 16'd0;
            r_fail_cnt   <= 16'd0;
            r_round_cnt  <= 8'd0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_stress_vec <= stress_vec;
                r_n_rounds   <= n_rounds;
                r_lfsr       <= c_seed;
                r_fail_cnt   <= 16'd0;
                r_round_cnt  <= 8'd0;
                r_phase_cnt  <= 16'd0;
                r_dut_in     <= stress_vec;
            end else if (w_zero_run) begin
                r_fail_cnt  <= 16'd0;
                r_round_cnt <= 8'd0;
                r_done      <= 1'b1;
            end else if (w_abort_run) begin
                r_dut_in    <= 10'h000;
                r_phase_cnt <= 16'd0;
            end else if (r_state == c_st_stress) begin
                if (w_stress_last) begin
                    r_phase_cnt <= 16'd0;
                    r_dut_in    <= r_lfsr;
                end else begin
                    r_phase_cnt <= r_phase_cnt + 16'd1;
                end
            end else if (r_state == c_st_meas) begin
                r_fail_cnt <= w_fail_sat;
                r_lfsr     <= w_lfsr_nxt;
                if (w_meas_last) begin
                    r_phase_cnt <= 16'd0;
                    r_round_cnt <= w_round_inc;
                    if (w_run_end) begin
                        r_dut_in <= 10'h000;
                        r_done   <= 1'b1;
                    end else begin
                        r_dut_in <= r_stress_vec;
                    end
                end else begin
                    r_phase_cnt <= r_phase_cnt + 16'd1;
                    r_dut_in    <= w_lfsr_nxt;
                end
            end
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = (r_state == c_st_stress) || (r_state == c_st_meas);
    assign done      = r_done;
    assign fail_cnt  = r_fail_cnt;
    assign round_cnt = r_round_cnt;

endmodule

`default_nettype wire
